ccg_bist_ctrl: RTL and testbench

Self-test controller for the generated combinational benchmark netlists (the 20-input / 18-output CCGRCG family). It drives each netlist's inputs with an LFSR pattern stream and compacts its outputs into a MISR signature. The result is one signature per run that can be compared across synthesis variants (raw, RESYN2, etc.). It sits beside the benchmark instance and owns both ends of the netlist's I/O: it transmits stimulus to the netlist inputs and receives the netlist outputs.

---
 rtl/ccg_bist_pkg.sv | 27 ++
 rtl/ccg_bist_if.sv | 31 +++
 rtl/ccg_misr.sv | 26 ++
 rtl/ccg_bist_ctrl.sv | 110 +++++++++++
 tb/tb_ccg_bist_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ccg_bist_pkg.sv
// ccg_bist_pkg: shared types and defaults for the CCGRCG self-test controller.
//   bist_state_e : controller state (IDLE / RUN / DONE)
//   DEF_*        : default widths, tap masks and seeds
//   eff_seed()   : maps an all-zero LFSR seed to 1 so the LFSR never locks up
package ccg_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_e;

  localparam int          DEF_N_IN       = 20;
  localparam int          DEF_N_OUT      = 18;
  localparam int          DEF_PATTERNS   = 1024;
  localparam logic [19:0] DEF_LFSR_TAPS  = 20'h90000;  // x^20+x^17+1
  localparam logic [19:0] DEF_LFSR_SEED  = 20'h00001;
  localparam logic [17:0] DEF_MISR_TAPS  = 18'h20400;  // x^18+x^11+1
  localparam logic [17:0] DEF_MISR_SEED  = 18'h00000;
  localparam logic [17:0] DEF_GOLDEN_SIG = 18'h00000;

  // Zero is the LFSR's only stuck state; substitute 1.
  function automatic logic [63:0] eff_seed(input logic [63:0] seed);
    return (seed == '0) ? 64'd1 : seed;
  endfunction

endpackage

// File: rtl/ccg_bist_if.sv
// ccg_bist_if: run control + netlist I/O of the self-test controller.
//   master : testbench / system side (drives start, abort, netlist response)
//   slave  : ccg_bist_ctrl side (drives stimulus, status, signature, count)
// Macro CCG_BIST_GOLDEN_CMP_EN adds pass_o.
interface ccg_bist_if #(
  parameter int N_IN  = 20,
  parameter int N_OUT = 18,
  parameter int CNT_W = 11
);
  logic             start_i;
  logic             abort_i;
  logic [N_IN-1:0]  stim_o;
  logic [N_OUT-1:0] resp_i;
  logic             busy_o;
  logic             done_o;
  logic [N_OUT-1:0] signature_o;
  logic [CNT_W-1:0] pat_cnt_o;
`ifdef CCG_BIST_GOLDEN_CMP_EN
  logic             pass_o;

  modport master (output start_i, abort_i, resp_i,
                  input  stim_o, busy_o, done_o, signature_o, pat_cnt_o, pass_o);
  modport slave  (input  start_i, abort_i, resp_i,
                  output stim_o, busy_o, done_o, signature_o, pat_cnt_o, pass_o);
`else
  modport master (output start_i, abort_i, resp_i,
                  input  stim_o, busy_o, done_o, signature_o, pat_cnt_o);
  modport slave  (input  start_i, abort_i, resp_i,
                  output stim_o, busy_o, done_o, signature_o, pat_cnt_o);
`endif
endinterface

// File: rtl/ccg_misr.sv
// ccg_misr: multiple-input signature register.
//   clk, rst_n : clock, async active-low reset (signature -> SEED)
//   en         : absorb din this edge
//   reseed     : load SEED (wins over en)
//   din        : parallel response word
//   sig        : current signature
module ccg_misr import ccg_bist_pkg::*; #(
  parameter int           W    = DEF_N_OUT,
  parameter logic [W-1:0] TAPS = DEF_MISR_TAPS,
  parameter logic [W-1:0] SEED = DEF_MISR_SEED
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         reseed,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sig <= SEED;
    else if (reseed) sig <= SEED;
    else if (en)     sig <= {sig[W-2:0], ^(sig & TAPS)} ^ din;
  end

endmodule

// File: rtl/ccg_bist_ctrl.sv
// ccg_bist_ctrl: LFSR-stimulus / MISR-compaction self-test controller for the
// 20-in / 18-out CCGRCG benchmark netlists.
//   clk, rst_n : clock, async active-low reset
//   bus        : ccg_bist_if.slave
//     start_i/abort_i in, resp_i in (netlist outputs),
//     stim_o out (registered netlist inputs), busy_o, done_o,
//     signature_o, pat_cnt_o out; pass_o out with CCG_BIST_GOLDEN_CMP_EN.
// Every output comes from a register or from state decode only, so there is no
// combinational input-to-output path.
module ccg_bist_ctrl import ccg_bist_pkg::*; #(
  parameter int              N_IN       = DEF_N_IN,
  parameter int              N_OUT      = DEF_N_OUT,
  parameter int              PATTERNS   = DEF_PATTERNS,
  parameter logic [N_IN-1:0]  LFSR_TAPS  = DEF_LFSR_TAPS,
  parameter logic [N_IN-1:0]  LFSR_SEED  = DEF_LFSR_SEED,
  parameter logic [N_OUT-1:0] MISR_TAPS  = DEF_MISR_TAPS,
  parameter logic [N_OUT-1:0] MISR_SEED  = DEF_MISR_SEED,
  parameter logic [N_OUT-1:0] GOLDEN_SIG = DEF_GOLDEN_SIG
) (
  input logic      clk,
  input logic      rst_n,
  ccg_bist_if.slave bus
);

  localparam int               CNT_W     = $clog2(PATTERNS + 1);
  localparam logic [N_IN-1:0]  STIM_SEED = N_IN'(eff_seed(64'(LFSR_SEED)));
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PATTERNS - 1);

  bist_state_e      state_q, state_d;
  logic [N_IN-1:0]  stim_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_OUT-1:0] sig;
  logic             launch, advance, last_pat;
  logic             busy, done, pass;

  // abort beats start; an aborted RUN edge absorbs nothing
  assign launch   = (state_q != ST_RUN) && bus.start_i && !bus.abort_i;
  assign advance  = (state_q == ST_RUN) && !bus.abort_i;
  assign last_pat = (cnt_q == LAST_CNT);

  // ---- FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.abort_i)   state_d = ST_IDLE;
        else if (last_pat) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.abort_i)   state_d = ST_IDLE;
        else if (launch)   state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs (state decode only)
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    // signature holds throughout DONE, so comparing it here equals
    // latching the compare on DONE entry
    pass = done && (sig == GOLDEN_SIG);
  end

  // ---- inline Fibonacci LFSR; also steps on the final pattern edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       stim_q <= STIM_SEED;
    else if (launch)  stim_q <= STIM_SEED;
    else if (advance) stim_q <= {stim_q[N_IN-2:0], ^(stim_q & LFSR_TAPS)};
  end

  // ---- pattern counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (launch)  cnt_q <= '0;
    else if (advance) cnt_q <= cnt_q + CNT_W'(1);
  end

  // resp_i is sampled on the edge that replaces stim_o
  ccg_misr #(.W(N_OUT), .TAPS(MISR_TAPS), .SEED(MISR_SEED)) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (advance),
    .reseed (launch),
    .din    (bus.resp_i),
    .sig    (sig)
  );

  assign bus.stim_o      = stim_q;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.signature_o = sig;
  assign bus.pat_cnt_o   = cnt_q;

`ifdef CCG_BIST_GOLDEN_CMP_EN
  assign bus.pass_o = pass;
`else
  logic unused_pass;
  assign unused_pass = pass;
`endif

endmodule

// File: tb/tb_ccg_bist_ctrl.sv
// tb_ccg_bist_ctrl: directed self-checking bench for ccg_bist_ctrl.
// Three instances, all with loopback resp_i = stim_o[17:0]:
//   u_a : PATTERNS=3, default seed, GOLDEN_SIG=4
//   u_z : PATTERNS=3, LFSR_SEED=0,  GOLDEN_SIG=5
//   u_b : PATTERNS=1024, defaults
// Build with +define+CCG_BIST_GOLDEN_CMP_EN to also check pass_o.
module tb_ccg_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ccg_bist_if #(.N_IN(20), .N_OUT(18), .CNT_W(2))  if_a ();
  ccg_bist_if #(.N_IN(20), .N_OUT(18), .CNT_W(2))  if_z ();
  ccg_bist_if #(.N_IN(20), .N_OUT(18), .CNT_W(11)) if_b ();

  assign if_a.resp_i = if_a.stim_o[17:0];
  assign if_z.resp_i = if_z.stim_o[17:0];
  assign if_b.resp_i = if_b.stim_o[17:0];

  ccg_bist_ctrl #(.PATTERNS(3), .GOLDEN_SIG(18'h00004)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  ccg_bist_ctrl #(.PATTERNS(3), .LFSR_SEED(20'h00000), .GOLDEN_SIG(18'h00005)) u_z (
    .clk(clk), .rst_n(rst_n), .bus(if_z));
  ccg_bist_ctrl #(.PATTERNS(1024)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));

  // Reference signature of a loopback run with default taps/seeds.
  function automatic logic [17:0] model_sig(input int n);
    logic [19:0] s;
    logic [17:0] m;
    s = 20'h00001;
    m = 18'h00000;
    for (int i = 0; i < n; i++) begin
      m = {m[16:0], ^(m & 18'h20400)} ^ s[17:0];
      s = {s[18:0], ^(s & 20'h90000)};
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (if_a.stim_o !== 20'h00001) begin failures++; $display("FAIL reset_stim got=%h exp=%h", if_a.stim_o, 20'h00001); end
    checks++; if (if_a.signature_o !== 18'h0) begin failures++; $display("FAIL reset_sig got=%h exp=0", if_a.signature_o); end
    checks++; if (if_a.pat_cnt_o !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", if_a.pat_cnt_o); end
    checks++; if (if_a.busy_o !== 1'b0 || if_a.done_o !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", if_a.busy_o, if_a.done_o); end
    checks++; if (if_z.stim_o !== 20'h00001) begin failures++; $display("FAIL reset_zero_seed_stim got=%h exp=00001", if_z.stim_o); end
`ifdef CCG_BIST_GOLDEN_CMP_EN
    checks++; if (if_a.pass_o !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", if_a.pass_o); end
`endif
  endtask

  task automatic test_loopback();
    logic [19:0] exp_stim [3];
    int busy_cycles;
    exp_stim[0] = 20'h1; exp_stim[1] = 20'h2; exp_stim[2] = 20'h4;
    busy_cycles = 0;
    if_a.start_i = 1'b1;
    tick();  // start edge (edge 1)
    if_a.start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (if_a.stim_o !== exp_stim[i]) begin failures++; $display("FAIL loop_stim[%0d] got=%h exp=%h", i, if_a.stim_o, exp_stim[i]); end
      checks++; if (if_a.done_o !== 1'b0) begin failures++; $display("FAIL loop_done_early[%0d] got=%b exp=0", i, if_a.done_o); end
      if (if_a.busy_o === 1'b1) busy_cycles++;
      tick();  // edges 2..4
    end
    checks++; if (if_a.done_o !== 1'b1 || if_a.busy_o !== 1'b0) begin failures++; $display("FAIL loop_done_edge4 got done=%b busy=%b exp done=1 busy=0", if_a.done_o, if_a.busy_o); end
    checks++; if (busy_cycles != 3) begin failures++; $display("FAIL loop_busy_cycles got=%0d exp=3", busy_cycles); end
    checks++; if (if_a.signature_o !== 18'h00004) begin failures++; $display("FAIL loop_sig got=%h exp=00004", if_a.signature_o); end
    checks++; if (if_a.pat_cnt_o !== 2'd3) begin failures++; $display("FAIL loop_cnt got=%0d exp=3", if_a.pat_cnt_o); end
    checks++; if (if_a.stim_o !== 20'h00008) begin failures++; $display("FAIL loop_stim_final got=%h exp=00008", if_a.stim_o); end
`ifdef CCG_BIST_GOLDEN_CMP_EN
    checks++; if (if_a.pass_o !== 1'b1) begin failures++; $display("FAIL loop_pass got=%b exp=1", if_a.pass_o); end
`endif
    tick(); tick();
    checks++; if (if_a.signature_o !== 18'h00004 || if_a.pat_cnt_o !== 2'd3 || if_a.done_o !== 1'b1) begin failures++; $display("FAIL loop_hold got sig=%h cnt=%0d done=%b exp 00004/3/1", if_a.signature_o, if_a.pat_cnt_o, if_a.done_o); end
  endtask

  task automatic test_back_to_back();
    if_a.start_i = 1'b1;  // start from DONE
    tick();
    if_a.start_i = 1'b0;
    checks++; if (if_a.busy_o !== 1'b1 || if_a.done_o !== 1'b0 || if_a.pat_cnt_o !== 2'd0 || if_a.stim_o !== 20'h1 || if_a.signature_o !== 18'h0) begin
      failures++; $display("FAIL b2b_reseed got busy=%b done=%b cnt=%0d stim=%h sig=%h exp 1/0/0/00001/00000", if_a.busy_o, if_a.done_o, if_a.pat_cnt_o, if_a.stim_o, if_a.signature_o); end
    tick(); tick(); tick();
    checks++; if (if_a.done_o !== 1'b1 || if_a.signature_o !== 18'h00004) begin failures++; $display("FAIL b2b_result got done=%b sig=%h exp 1/00004", if_a.done_o, if_a.signature_o); end
  endtask

  task automatic test_abort_final();
    if_a.start_i = 1'b1;
    tick();
    if_a.start_i = 1'b0;
    tick(); tick();  // count 2; next edge would be the last
    if_a.abort_i = 1'b1;
    tick();
    if_a.abort_i = 1'b0;
    checks++; if (if_a.done_o !== 1'b0 || if_a.busy_o !== 1'b0) begin failures++; $display("FAIL abort_final_state got done=%b busy=%b exp 0/0", if_a.done_o, if_a.busy_o); end
    checks++; if (if_a.pat_cnt_o !== 2'd2 || if_a.signature_o !== model_sig(2)) begin failures++; $display("FAIL abort_final_freeze got cnt=%0d sig=%h exp 2/%h", if_a.pat_cnt_o, if_a.signature_o, model_sig(2)); end
`ifdef CCG_BIST_GOLDEN_CMP_EN
    checks++; if (if_a.pass_o !== 1'b0) begin failures++; $display("FAIL abort_final_pass got=%b exp=0", if_a.pass_o); end
`endif
  endtask

  task automatic test_zero_seed();
    logic [19:0] exp_stim [4];
    exp_stim[0] = 20'h1; exp_stim[1] = 20'h2; exp_stim[2] = 20'h4; exp_stim[3] = 20'h8;
    if_z.start_i = 1'b1;
    tick();
    if_z.start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (if_z.stim_o !== exp_stim[i]) begin failures++; $display("FAIL zero_seed_stim[%0d] got=%h exp=%h", i, if_z.stim_o, exp_stim[i]); end
      if (i < 3) tick();
    end
    checks++; if (if_z.done_o !== 1'b1 || if_z.signature_o !== 18'h00004) begin failures++; $display("FAIL zero_seed_sig got done=%b sig=%h exp 1/00004", if_z.done_o, if_z.signature_o); end
`ifdef CCG_BIST_GOLDEN_CMP_EN
    checks++; if (if_z.pass_o !== 1'b0) begin failures++; $display("FAIL golden_mismatch_pass got=%b exp=0", if_z.pass_o); end
`endif
    // abort in DONE -> IDLE, then abort in IDLE does nothing
    if_z.abort_i = 1'b1;
    tick();
    checks++; if (if_z.done_o !== 1'b0 || if_z.busy_o !== 1'b0) begin failures++; $display("FAIL abort_done got done=%b busy=%b exp 0/0", if_z.done_o, if_z.busy_o); end
    tick();
    if_z.abort_i = 1'b0;
    checks++; if (if_z.signature_o !== 18'h00004 || if_z.pat_cnt_o !== 2'd3 || if_z.busy_o !== 1'b0) begin failures++; $display("FAIL abort_idle got sig=%h cnt=%0d busy=%b exp 00004/3/0", if_z.signature_o, if_z.pat_cnt_o, if_z.busy_o); end
  endtask

  task automatic wait_done_b(input int budget, output int n);
    n = 0;
    while (if_b.done_o !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_start_ignored();
    int n;
    if_b.start_i = 1'b1;
    tick();
    if_b.start_i = 1'b0;
    repeat (10) tick();
    if_b.start_i = 1'b1;  // must be ignored in RUN
    tick();
    if_b.start_i = 1'b0;
    checks++; if (if_b.pat_cnt_o !== 11'd11 || if_b.busy_o !== 1'b1) begin failures++; $display("FAIL start_ignored_cnt got cnt=%0d busy=%b exp 11/1", if_b.pat_cnt_o, if_b.busy_o); end
    wait_done_b(2000, n);
    checks++; if (n != 1013) begin failures++; $display("FAIL start_ignored_latency got=%0d exp=1013", n); end
    checks++; if (if_b.signature_o !== model_sig(1024)) begin failures++; $display("FAIL start_ignored_sig got=%h exp=%h", if_b.signature_o, model_sig(1024)); end
    checks++; if (if_b.pat_cnt_o !== 11'd1024) begin failures++; $display("FAIL start_ignored_cnt_final got=%0d exp=1024", if_b.pat_cnt_o); end
    // start and abort together in DONE: abort wins
    if_b.start_i = 1'b1;
    if_b.abort_i = 1'b1;
    tick();
    if_b.start_i = 1'b0;
    if_b.abort_i = 1'b0;
    checks++; if (if_b.busy_o !== 1'b0 || if_b.done_o !== 1'b0 || if_b.pat_cnt_o !== 11'd1024) begin failures++; $display("FAIL abort_beats_start got busy=%b done=%b cnt=%0d exp 0/0/1024", if_b.busy_o, if_b.done_o, if_b.pat_cnt_o); end
  endtask

  task automatic test_abort_midrun();
    int n;
    if_b.start_i = 1'b1;
    tick();
    if_b.start_i = 1'b0;
    tick(); tick();
    if_b.abort_i = 1'b1;  // count is 2
    tick();
    if_b.abort_i = 1'b0;
    checks++; if (if_b.busy_o !== 1'b0 || if_b.done_o !== 1'b0 || if_b.pat_cnt_o !== 11'd2) begin failures++; $display("FAIL abort_mid got busy=%b done=%b cnt=%0d exp 0/0/2", if_b.busy_o, if_b.done_o, if_b.pat_cnt_o); end
    tick();
    checks++; if (if_b.pat_cnt_o !== 11'd2 || if_b.signature_o !== model_sig(2)) begin failures++; $display("FAIL abort_mid_freeze got cnt=%0d sig=%h exp 2/%h", if_b.pat_cnt_o, if_b.signature_o, model_sig(2)); end
    if_b.start_i = 1'b1;
    tick();
    if_b.start_i = 1'b0;
    wait_done_b(2000, n);
    checks++; if (n != 1024) begin failures++; $display("FAIL abort_restart_latency got=%0d exp=1024", n); end
    checks++; if (if_b.signature_o !== model_sig(1024)) begin failures++; $display("FAIL abort_restart_sig got=%h exp=%h", if_b.signature_o, model_sig(1024)); end
  endtask

  task automatic test_reset_midrun();
    if_b.start_i = 1'b1;
    tick();
    if_b.start_i = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if_b.busy_o !== 1'b0 || if_b.done_o !== 1'b0 || if_b.pat_cnt_o !== 11'd0) begin failures++; $display("FAIL rst_mid_ctrl got busy=%b done=%b cnt=%0d exp 0/0/0", if_b.busy_o, if_b.done_o, if_b.pat_cnt_o); end
    checks++; if (if_b.stim_o !== 20'h00001 || if_b.signature_o !== 18'h0) begin failures++; $display("FAIL rst_mid_data got stim=%h sig=%h exp 00001/00000", if_b.stim_o, if_b.signature_o); end
    #1 rst_n = 1'b1;
    tick();
    checks++; if (if_b.busy_o !== 1'b0 || if_b.pat_cnt_o !== 11'd0) begin failures++; $display("FAIL rst_mid_idle got busy=%b cnt=%0d exp 0/0", if_b.busy_o, if_b.pat_cnt_o); end
  endtask

  initial begin
    if_a.start_i = 1'b0; if_a.abort_i = 1'b0;
    if_z.start_i = 1'b0; if_z.abort_i = 1'b0;
    if_b.start_i = 1'b0; if_b.abort_i = 1'b0;
    #12;
    test_reset();
    #3 rst_n = 1'b1;
    tick();
    test_loopback();
    test_back_to_back();
    test_abort_final();
    test_zero_seed();
    test_start_ignored();
    test_abort_midrun();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
